// File: rtl/mem_req_arb.sv
// Multi-channel memory request arbiter: per-channel request FIFOs, round-robin
// arbitration with a lock while L2 stalls, outstanding-request limits and response routing.
module mem_req_arb #(
    parameter int NUM_CH    = 2,
    parameter int DEPTH     = 4,
    parameter int MAX_OUTST = 4,
    parameter int PKT_W     = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          req_valid,
    input  logic [NUM_CH*PKT_W-1:0]    req_pkt,
    output logic [NUM_CH-1:0]          req_ready,
    input  logic [NUM_CH-1:0]          flush,
    output logic                       l2_req_valid,
    output logic [PKT_W-1:0]           l2_req_pkt,
    output logic [$clog2(NUM_CH)-1:0]  l2_req_ch,
    input  logic                       l2_req_ready,
    input  logic                       l2_rsp_valid,
    input  logic [$clog2(NUM_CH)-1:0]  l2_rsp_ch,
    input  logic [PKT_W-1:0]           l2_rsp_pkt,
    output logic [NUM_CH-1:0]          rsp_valid,
    output logic [PKT_W-1:0]           rsp_pkt,
    output logic                       idle
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUTST + 1);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } arb_state_t;

    arb_state_t        state_q;
    logic [CH_W-1:0]   lock_ch_q;
    logic [CH_W-1:0]   rr_ptr_q;
    logic [PKT_W-1:0]  mem_q    [NUM_CH][DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q [NUM_CH];
    logic [PTR_W-1:0]  wr_ptr_q [NUM_CH];
    logic [CNT_W-1:0]  count_q  [NUM_CH];
    logic [OUT_W-1:0]  outst_q  [NUM_CH];
    logic [NUM_CH-1:0] rsp_valid_q;
    logic [PKT_W-1:0]  rsp_pkt_q;

    logic [NUM_CH-1:0] eligible_s;
    logic [NUM_CH-1:0] push_s;
    logic [NUM_CH-1:0] pop_s;
    logic [NUM_CH-1:0] hold_s;
    logic [NUM_CH-1:0] rsp_hit_s;
    logic              win_found_s;
    logic [CH_W-1:0]   win_ch_s;
    logic [CH_W-1:0]   idx_s;
    logic              take_s;
    logic [CH_W-1:0]   sel_ch_s;
    logic              grant_s;
    int                idx_v;

    // Per-channel eligibility and enqueue readiness from registered state
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            eligible_s[c] = (count_q[c] != '0) && (outst_q[c] < OUT_W'(MAX_OUTST));
            req_ready[c]  = (count_q[c] < CNT_W'(DEPTH)) && !flush[c];
        end
    end

    // Round-robin scan from rr_ptr and selection of the presented channel
    always_comb begin
        win_found_s = 1'b0;
        win_ch_s    = '0;
        idx_v       = 0;
        idx_s       = '0;
        take_s      = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx_v       = int'(rr_ptr_q) + i;
            idx_v       = (idx_v >= NUM_CH) ? (idx_v - NUM_CH) : idx_v;
            idx_s       = CH_W'(idx_v);
            take_s      = !win_found_s && eligible_s[idx_s];
            win_ch_s    = take_s ? idx_s : win_ch_s;
            win_found_s = win_found_s || take_s;
        end
        sel_ch_s     = (state_q == S_LOCKED) ? lock_ch_q : win_ch_s;
        l2_req_valid = (state_q == S_LOCKED) || win_found_s;
        l2_req_ch    = sel_ch_s;
        l2_req_pkt   = mem_q[sel_ch_s][rd_ptr_q[sel_ch_s]];
        grant_s      = l2_req_valid && l2_req_ready;
    end

    // Per-channel push/pop/hold strobes; a held entry survives a flush
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            push_s[c]    = req_valid[c] && req_ready[c];
            pop_s[c]     = grant_s && (sel_ch_s == CH_W'(c));
            hold_s[c]    = l2_req_valid && !l2_req_ready && (sel_ch_s == CH_W'(c));
            rsp_hit_s[c] = l2_rsp_valid && (l2_rsp_ch == CH_W'(c));
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                rd_ptr_q[c] <= '0;
                wr_ptr_q[c] <= '0;
                count_q[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (flush[c]) begin
                    rd_ptr_q[c] <= pop_s[c] ? (rd_ptr_q[c] + PTR_W'(1)) : rd_ptr_q[c];
                    wr_ptr_q[c] <= (pop_s[c] || hold_s[c]) ? (rd_ptr_q[c] + PTR_W'(1)) : rd_ptr_q[c];
                    count_q[c]  <= hold_s[c] ? CNT_W'(1) : CNT_W'(0);
                end else begin
                    rd_ptr_q[c] <= pop_s[c] ? (rd_ptr_q[c] + PTR_W'(1)) : rd_ptr_q[c];
                    wr_ptr_q[c] <= push_s[c] ? (wr_ptr_q[c] + PTR_W'(1)) : wr_ptr_q[c];
                    count_q[c]  <= count_q[c] + CNT_W'(push_s[c]) - CNT_W'(pop_s[c]);
                end
            end
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (push_s[c]) begin
                mem_q[c][wr_ptr_q[c]] <= req_pkt[c*PKT_W +: PKT_W];
            end
        end
    end

    // Outstanding counters; a grant and a response together cancel out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                outst_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (pop_s[c] && !rsp_hit_s[c]) begin
                    outst_q[c] <= outst_q[c] + OUT_W'(1);
                end else if (rsp_hit_s[c] && !pop_s[c] && (outst_q[c] != '0)) begin
                    outst_q[c] <= outst_q[c] - OUT_W'(1);
                end else begin
                    outst_q[c] <= outst_q[c];
                end
            end
        end
    end

    // Arbiter lock FSM and round-robin pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            lock_ch_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (win_found_s && !l2_req_ready) begin
                        state_q   <= S_LOCKED;
                        lock_ch_q <= win_ch_s;
                    end else begin
                        state_q   <= S_IDLE;
                    end
                end
                S_LOCKED: begin
                    state_q <= l2_req_ready ? S_IDLE : S_LOCKED;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
            if (grant_s) begin
                rr_ptr_q <= (sel_ch_s == CH_W'(NUM_CH - 1)) ? CH_W'(0) : (sel_ch_s + CH_W'(1));
            end else begin
                rr_ptr_q <= rr_ptr_q;
            end
        end
    end

    // One-cycle response routing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_q <= '0;
            rsp_pkt_q   <= '0;
        end else begin
            rsp_valid_q <= rsp_hit_s;
            rsp_pkt_q   <= l2_rsp_pkt;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_pkt   = rsp_pkt_q;

    // Quiescence: no lock, no queued entries, nothing outstanding
    always_comb begin
        idle = (state_q == S_IDLE);
        for (int c = 0; c < NUM_CH; c++) begin
            idle = idle && (count_q[c] == '0) && (outst_q[c] == '0);
        end
    end

endmodule

// File: tb/tb_mem_req_arb.sv
// Bench for mem_req_arb: directed scenarios plus random traffic, all checked
// cycle-by-cycle against a queue-based reference model.
module tb_mem_req_arb;

    localparam int NUM_CH    = 2;
    localparam int DEPTH     = 4;
    localparam int MAX_OUTST = 4;
    localparam int PKT_W     = 64;

    logic         clk;
    logic         reset;
    logic [1:0]   req_valid;
    logic [127:0] req_pkt;
    logic [1:0]   req_ready;
    logic [1:0]   flush;
    logic         l2_req_valid;
    logic [63:0]  l2_req_pkt;
    logic         l2_req_ch;
    logic         l2_req_ready;
    logic         l2_rsp_valid;
    logic         l2_rsp_ch;
    logic [63:0]  l2_rsp_pkt;
    logic [1:0]   rsp_valid;
    logic [63:0]  rsp_pkt;
    logic         idle;

    int checks;
    int failures;
    int gcount;

    // reference model state
    logic [63:0] mq [NUM_CH][$];
    int          mout [NUM_CH];
    int          mrr;
    bit          mlocked;
    int          mlock_ch;
    logic [1:0]  mrsp_v;
    logic [63:0] mrsp_pkt;

    mem_req_arb #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .PKT_W(PKT_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_pkt(req_pkt), .req_ready(req_ready), .flush(flush),
        .l2_req_valid(l2_req_valid), .l2_req_pkt(l2_req_pkt), .l2_req_ch(l2_req_ch),
        .l2_req_ready(l2_req_ready),
        .l2_rsp_valid(l2_rsp_valid), .l2_rsp_ch(l2_rsp_ch), .l2_rsp_pkt(l2_rsp_pkt),
        .rsp_valid(rsp_valid), .rsp_pkt(rsp_pkt), .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            mq[c].delete();
            mout[c] = 0;
        end
        mrr      = 0;
        mlocked  = 0;
        mlock_ch = 0;
        mrsp_v   = 2'b00;
        mrsp_pkt = 64'h0;
    endtask

    task automatic clear_inputs();
        req_valid    = 2'b00;
        req_pkt      = 128'h0;
        flush        = 2'b00;
        l2_req_ready = 1'b0;
        l2_rsp_valid = 1'b0;
        l2_rsp_ch    = 1'b0;
        l2_rsp_pkt   = 64'h0;
    endtask

    // One clock: compare DUT against model mid-cycle, advance model, return just after the edge
    task automatic cycle();
        bit          ev;
        int          ech;
        int          c;
        bit          grant;
        bit          popc, holdc, pushc, incc, decc;
        bit          exp_idle;
        logic [1:0]  exp_ready;
        logic [63:0] tmp;
        @(negedge clk);
        ev  = 0;
        ech = 0;
        if (mlocked) begin
            ev  = 1;
            ech = mlock_ch;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                c = (mrr + i) % NUM_CH;
                if (!ev && mq[c].size() > 0 && mout[c] < MAX_OUTST) begin
                    ev  = 1;
                    ech = c;
                end
            end
        end
        exp_idle = !mlocked;
        for (int k = 0; k < NUM_CH; k++) begin
            exp_ready[k] = (mq[k].size() < DEPTH) && !flush[k];
            if (mq[k].size() != 0 || mout[k] != 0) exp_idle = 0;
        end
        chk("l2_req_valid", {63'h0, l2_req_valid}, {63'h0, ev});
        if (ev) begin
            chk("l2_req_ch", {63'h0, l2_req_ch}, 64'(ech));
            chk("l2_req_pkt", l2_req_pkt, mq[ech][0]);
        end
        chk("req_ready", {62'h0, req_ready}, {62'h0, exp_ready});
        chk("idle", {63'h0, idle}, {63'h0, exp_idle});
        chk("rsp_valid", {62'h0, rsp_valid}, {62'h0, mrsp_v});
        chk("rsp_pkt", rsp_pkt, mrsp_pkt);
        if (l2_req_valid && l2_req_ready) gcount++;

        grant = ev && l2_req_ready;
        for (int k = 0; k < NUM_CH; k++) begin
            popc  = grant && (ech == k);
            holdc = ev && (ech == k) && !l2_req_ready;
            pushc = req_valid[k] && (mq[k].size() < DEPTH) && !flush[k];
            if (popc) tmp = mq[k].pop_front();
            if (flush[k]) begin
                if (holdc) begin
                    tmp = mq[k][0];
                    mq[k].delete();
                    mq[k].push_back(tmp);
                end else begin
                    mq[k].delete();
                end
            end else if (pushc) begin
                mq[k].push_back(req_pkt[k*64 +: 64]);
            end
            incc = popc;
            decc = l2_rsp_valid && (int'(l2_rsp_ch) == k);
            if (incc && !decc) mout[k] = mout[k] + 1;
            else if (decc && !incc && mout[k] > 0) mout[k] = mout[k] - 1;
            mrsp_v[k] = decc;
        end
        mrsp_pkt = l2_rsp_pkt;
        if (grant) mrr = (ech + 1) % NUM_CH;
        if (mlocked) begin
            if (l2_req_ready) mlocked = 0;
        end else if (ev && !l2_req_ready) begin
            mlocked  = 1;
            mlock_ch = ech;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic respond(input logic ch, input logic [63:0] pkt);
        l2_rsp_valid = 1'b1;
        l2_rsp_ch    = ch;
        l2_rsp_pkt   = pkt;
        cycle();
        l2_rsp_valid = 1'b0;
    endtask

    initial begin
        int ch;
        checks   = 0;
        failures = 0;
        gcount   = 0;
        reset    = 1'b1;
        clear_inputs();
        model_reset();

        // reset state, before any edge
        #1;
        chk("rst_l2_req_valid", {63'h0, l2_req_valid}, 64'h0);
        chk("rst_idle", {63'h0, idle}, 64'h1);
        chk("rst_req_ready", {62'h0, req_ready}, 64'h3);
        chk("rst_rsp_valid", {62'h0, rsp_valid}, 64'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // both channels one request each, L2 always ready
        l2_req_ready = 1'b1;
        req_valid    = 2'b11;
        req_pkt      = {64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0000};
        cycle();
        req_valid = 2'b00;
        cycle();
        cycle();
        chk("rr_back_to_0", 64'(dut.rr_ptr_q), 64'h0);
        chk("outst0_is_1", 64'(dut.outst_q[0]), 64'h1);
        chk("outst1_is_1", 64'(dut.outst_q[1]), 64'h1);
        respond(1'b0, 64'hBEEF_0000_0000_0000);
        respond(1'b1, 64'hBEEF_0000_0000_0001);
        cycle();

        // ch1 locked for 3 stalled cycles while ch0 enqueues
        l2_req_ready = 1'b0;
        req_valid    = 2'b10;
        req_pkt      = {64'hB1B1_B1B1_0000_1111, 64'h0};
        cycle();
        req_valid = 2'b01;
        req_pkt   = {64'h0, 64'hB0B0_B0B0_0000_0000};
        for (int k = 0; k < 3; k++) begin
            cycle();
            req_valid = 2'b00;
            chk("lock_ch_stable", {63'h0, l2_req_ch}, 64'h1);
            chk("lock_pkt_stable", l2_req_pkt, 64'hB1B1_B1B1_0000_1111);
        end
        l2_req_ready = 1'b1;
        cycle();
        chk("ch0_next", {63'h0, l2_req_ch}, 64'h0);
        cycle();
        respond(1'b1, 64'h1111);
        respond(1'b0, 64'h2222);
        cycle();

        // outstanding limit: 5 requests on ch0, 4 grants until a response
        gcount       = 0;
        l2_req_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            req_valid = 2'b01;
            req_pkt   = {64'h0, 64'hC000_0000_0000_0000 + 64'(k)};
            cycle();
        end
        req_valid = 2'b00;
        for (int k = 0; k < 3; k++) cycle();
        chk("max_outst_grants", 64'(gcount), 64'd4);
        chk("max_outst_blocked", {63'h0, l2_req_valid}, 64'h0);
        respond(1'b0, 64'hD00D_0000_0000_0000);
        chk("fifth_issued", {63'h0, l2_req_valid}, 64'h1);
        chk("fifth_pkt", l2_req_pkt, 64'hC000_0000_0000_0004);
        chk("rsp_valid_01", {62'h0, rsp_valid}, 64'h1);
        cycle();
        chk("fifth_granted", 64'(gcount), 64'd5);
        for (int k = 0; k < 4; k++) respond(1'b0, 64'hE000 + 64'(k));
        cycle();

        // fill ch1 while L2 stalls, then flush while locked
        l2_req_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req_valid = 2'b10;
            req_pkt   = {64'hD100_0000_0000_0000 + 64'(k), 64'h0};
            cycle();
        end
        req_valid = 2'b00;
        chk("full_ready1_low", {63'h0, req_ready[1]}, 64'h0);
        flush = 2'b10;
        cycle();
        flush = 2'b00;
        chk("flush_count_1", 64'(dut.count_q[1]), 64'h1);
        chk("flush_head_pkt", l2_req_pkt, 64'hD100_0000_0000_0000);
        l2_req_ready = 1'b1;
        cycle();
        respond(1'b1, 64'hF1F1);
        chk("idle_after_flush", {63'h0, idle}, 64'h1);
        cycle();

        // same-cycle grant and response at outst=2
        l2_req_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_valid = 2'b01;
            req_pkt   = {64'h0, 64'hE0E0_0000_0000_0000 + 64'(k)};
            cycle();
        end
        req_valid = 2'b00;
        chk("outst_before_2", 64'(dut.outst_q[0]), 64'd2);
        respond(1'b0, 64'h7777);
        chk("outst_stays_2", 64'(dut.outst_q[0]), 64'd2);

        // async reset in the middle of a lock
        l2_req_ready = 1'b0;
        req_valid    = 2'b10;
        req_pkt      = {64'hF0F0_0000_0000_0001, 64'h0};
        cycle();
        req_valid = 2'b00;
        cycle();
        chk("locked_before_rst", {63'h0, l2_req_valid}, 64'h1);
        reset = 1'b1;
        #2;
        chk("rst_mid_lock_valid", {63'h0, l2_req_valid}, 64'h0);
        chk("rst_mid_lock_idle", {63'h0, idle}, 64'h1);
        chk("rst_mid_lock_ready", {62'h0, req_ready}, 64'h3);
        model_reset();
        clear_inputs();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // random traffic against the model
        for (int n = 0; n < 600; n++) begin
            req_valid    = 2'($urandom);
            req_pkt      = {$urandom, $urandom, $urandom, $urandom};
            flush        = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b00;
            l2_req_ready = ($urandom_range(0, 3) != 0);
            l2_rsp_pkt   = {$urandom, $urandom};
            if ((mout[0] + mout[1]) > 0 && $urandom_range(0, 1) == 1) begin
                ch = $urandom_range(0, 1);
                if (mout[ch] == 0) ch = 1 - ch;
                l2_rsp_valid = 1'b1;
                l2_rsp_ch    = 1'(ch);
            end else begin
                l2_rsp_valid = 1'b0;
                l2_rsp_ch    = 1'($urandom);
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
